// File: rtl/window_conv_pkg.sv
// Shared RGB565 field layout and pipeline helpers for the window convolution block.
package window_conv_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb_t;

  // Multiply stage + one stage per adder-tree level + output stage.
  function automatic int latency(input int n);
    return 2 + $clog2(n);
  endfunction

endpackage

// File: rtl/conv_channel.sv
// Single colour channel: tap multiplies, pipelined binary adder tree, then
// round-half-up, fixed-point shift and clamp to [0, SAT_MAX].
module conv_channel
  import window_conv_pkg::*;
#(
  parameter int CHAN_W    = 5,
  parameter int COEF_W    = 8,
  parameter int N         = 16,
  parameter int FRAC_BITS = 6,
  parameter int SAT_MAX   = 31
) (
  input  logic                     clk_in,
  input  logic [CHAN_W-1:0]        chan_in [N],
  input  logic signed [COEF_W-1:0] coef_in [N],
  output logic [CHAN_W-1:0]        result_o
);

  localparam int K      = $clog2(N);
  localparam int NP     = 1 << K;
  localparam int PROD_W = CHAN_W + 1 + COEF_W;
  localparam int ACC_W  = PROD_W + K;
  localparam int NODES  = 2 * NP - 1;

  localparam logic signed [ACC_W:0] RND_S = (ACC_W + 1)'(1 << (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] MAX_S = (ACC_W + 1)'(SAT_MAX);

  logic signed [ACC_W-1:0] leaf_d [NP];
  logic signed [ACC_W-1:0] tree_q [NODES];
  logic signed [ACC_W:0]   rnd_s;

  // Leaves beyond N are padded with zero so the tree stays a full power of two.
  for (genvar e = 0; e < NP; e++) begin : g_leaf
    if (e < N) begin : g_tap
      logic signed [PROD_W-1:0] prod_s;
      assign prod_s    = $signed({1'b0, chan_in[e]}) * coef_in[e];
      assign leaf_d[e] = ACC_W'(prod_s);
    end else begin : g_pad
      assign leaf_d[e] = '0;
    end
  end

  // Heap-ordered tree: node n sums children 2n+1 and 2n+2, so every level is one register stage.
  always_ff @(posedge clk_in) begin
    for (int n = 0; n < NP - 1; n++) begin
      tree_q[n] <= tree_q[2*n+1] + tree_q[2*n+2];
    end
    for (int l = 0; l < NP; l++) begin
      tree_q[NP-1+l] <= leaf_d[l];
    end
  end

  // One guard bit keeps the rounding add from wrapping before the clamp.
  always_comb begin
    rnd_s = ($signed({tree_q[0][ACC_W-1], tree_q[0]}) + RND_S) >>> FRAC_BITS;
    if (rnd_s[ACC_W]) begin
      result_o = '0;
    end else if (rnd_s > MAX_S) begin
      result_o = CHAN_W'(SAT_MAX);
    end else begin
      result_o = rnd_s[CHAN_W-1:0];
    end
  end

endmodule

// File: rtl/window_conv.sv
// RGB565 window filter: runtime-loadable signed fixed-point kernel applied per
// channel, one window per cycle, fixed latency, no backpressure.
module window_conv
  import window_conv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int HOR_SIZE   = 4,
  parameter int VER_SIZE   = 4,
  parameter int COEF_WIDTH = 8,
  parameter int FRAC_BITS  = 6
) (
  input  logic                                          clk_in,
  input  logic                                          rst_n_in,
  input  logic                                          valid_in,
  input  logic [HOR_SIZE-1:0][VER_SIZE-1:0][WIDTH-1:0]  pixel_array_in,
  input  logic                                          coef_we_in,
  input  logic [$clog2(HOR_SIZE*VER_SIZE)-1:0]          coef_addr_in,
  input  logic signed [COEF_WIDTH-1:0]                  coef_data_in,
  output logic [WIDTH-1:0]                              pixel_out,
  output logic                                          valid_out
);

  localparam int N       = HOR_SIZE * VER_SIZE;
  localparam int LAT     = latency(N);
  localparam int ID_ADDR = (HOR_SIZE / 2) * VER_SIZE + (VER_SIZE / 2);
  localparam int ONE     = 1 << FRAC_BITS;

  if (WIDTH != 16) begin : g_width_check
    $error("window_conv: WIDTH must be 16 (RGB565)");
  end

  logic [R_W-1:0]               r_s [N];
  logic [G_W-1:0]               g_s [N];
  logic [B_W-1:0]               b_s [N];
  logic signed [COEF_WIDTH-1:0] coef_q [N];
  logic [LAT-1:0]               vld_q;
  logic [R_W-1:0]               r_res_s;
  logic [G_W-1:0]               g_res_s;
  logic [B_W-1:0]               b_res_s;
  rgb_t                         res_s;
  logic [WIDTH-1:0]             pix_d;
  logic [WIDTH-1:0]             pix_q;

  for (genvar i = 0; i < HOR_SIZE; i++) begin : g_col
    for (genvar j = 0; j < VER_SIZE; j++) begin : g_row
      rgb_t px_s;
      assign px_s               = pixel_array_in[i][j];
      assign r_s[i*VER_SIZE+j]  = px_s.r;
      assign g_s[i*VER_SIZE+j]  = px_s.g;
      assign b_s[i*VER_SIZE+j]  = px_s.b;
    end
  end

  // Kernel register file; reset and out-of-range writes leave the identity kernel intact.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int t = 0; t < N; t++) begin
        coef_q[t] <= (t == ID_ADDR) ? COEF_WIDTH'(ONE) : '0;
      end
    end else if (coef_we_in && (int'(coef_addr_in) < N)) begin
      coef_q[coef_addr_in] <= coef_data_in;
    end
  end

  conv_channel #(
    .CHAN_W(R_W), .COEF_W(COEF_WIDTH), .N(N), .FRAC_BITS(FRAC_BITS), .SAT_MAX((1 << R_W) - 1)
  ) u_red (
    .clk_in(clk_in), .chan_in(r_s), .coef_in(coef_q), .result_o(r_res_s)
  );

  conv_channel #(
    .CHAN_W(G_W), .COEF_W(COEF_WIDTH), .N(N), .FRAC_BITS(FRAC_BITS), .SAT_MAX((1 << G_W) - 1)
  ) u_green (
    .clk_in(clk_in), .chan_in(g_s), .coef_in(coef_q), .result_o(g_res_s)
  );

  conv_channel #(
    .CHAN_W(B_W), .COEF_W(COEF_WIDTH), .N(N), .FRAC_BITS(FRAC_BITS), .SAT_MAX((1 << B_W) - 1)
  ) u_blue (
    .clk_in(clk_in), .chan_in(b_s), .coef_in(coef_q), .result_o(b_res_s)
  );

  assign res_s = {r_res_s, g_res_s, b_res_s};

  // Valid bits shadow the data pipeline; only these are reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], valid_in};
    end
  end

  // Output pixel loads only for a valid window and otherwise holds.
  always_comb begin
    pix_d = pix_q;
    if (vld_q[LAT-2]) begin
      pix_d = res_s;
    end else begin
      pix_d = pix_q;
    end
  end

  // Output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pixel_out = pix_q;
  assign valid_out = vld_q[LAT-1];

endmodule

// File: tb/tb_window_conv.sv
// Self-checking bench for window_conv: directed scenarios plus randomized traffic
// against a per-channel arithmetic reference model with a due-cycle scoreboard.
module tb_window_conv;

  localparam int N   = 16;
  localparam int LAT = 6;

  typedef logic [3:0][3:0][15:0] win_t;
  typedef struct {
    int          due;
    logic [15:0] px;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  win_t              win;
  logic              we;
  logic [3:0]        addr;
  logic signed [7:0] data;
  logic [15:0]       pixel_out;
  logic              valid_out;

  int          kern [N];
  exp_t        exp_q [$];
  int          cyc;
  logic        exp_v;
  logic [15:0] exp_px;
  int          n_pass;
  int          n_total;
  win_t        zw;

  always #5 clk = ~clk;

  window_conv dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .pixel_array_in(win),
    .coef_we_in(we), .coef_addr_in(addr), .coef_data_in(data),
    .pixel_out(pixel_out), .valid_out(valid_out)
  );

  function automatic int clamp(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Reference: weighted sum per channel, round half up by 1/2 LSB, floor-divide by 64, clamp.
  function automatic logic [15:0] model(input win_t w);
    int r, g, b, k;
    logic [4:0] ro, bo;
    logic [5:0] go;
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        k = kern[i*4+j];
        r += int'(w[i][j][15:11]) * k;
        g += int'(w[i][j][10:5]) * k;
        b += int'(w[i][j][4:0]) * k;
      end
    end
    ro = 5'(clamp((r + 32) >>> 6, 31));
    go = 6'(clamp((g + 32) >>> 6, 63));
    bo = 5'(clamp((b + 32) >>> 6, 31));
    return {ro, go, bo};
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w[i][j] = 16'($urandom);
    return w;
  endfunction

  function automatic win_t fill_win(input logic [15:0] p);
    win_t w;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w[i][j] = p;
    return w;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N; t++) kern[t] = (t == 10) ? 64 : 0;
    exp_q.delete();
    exp_px = 16'h0000;
    exp_v  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, and set exp_v/exp_px for the sample after the edge.
  task automatic cycle(input logic v, input win_t w, input logic we_v, input int a, input int d);
    exp_t e;
    logic signed [7:0] dv;
    dv = 8'(d);
    valid_in = v; win = w; we = we_v; addr = 4'(a); data = dv;
    if (v) begin
      e.due = cyc + LAT;
      e.px  = model(w);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (we_v && a < N) kern[a] = int'(dv);
    cyc++;
    #1;
    exp_v = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_v  = 1'b1;
      exp_px = exp_q[0].px;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic load_kernel(input int vals [N]);
    for (int t = 0; t < N; t++) cycle(1'b0, zw, 1'b1, t, vals[t]);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; win = '0; we = 1'b0; addr = '0; data = '0;
    zw = '0; cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", valid_out);
    else n_pass++;
    n_total++;
    if (pixel_out !== 16'h0000) $display("FAIL reset_pixel: got %h, expected 0000", pixel_out);
    else n_pass++;
    n_total++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_identity();
    win_t w;
    int vcount, vpos;
    logic [15:0] vpx;
    w = '0; w[2][2] = 16'hF81F;
    vcount = 0; vpos = 0; vpx = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) cycle(1'b1, w, 1'b0, 0, 0);
      else cycle(1'b0, zw, 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL identity cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
      if (valid_out === 1'b1) begin vcount++; vpos = k; vpx = pixel_out; end
    end
    if (vcount != 1 || vpos != LAT || vpx !== 16'hF81F)
      $display("FAIL identity_pulse: got count=%0d at=%0d px=%h, expected count=1 at=%0d px=f81f", vcount, vpos, vpx, LAT);
    else n_pass++;
    n_total++;
  endtask

  // Single window through a given kernel, with an absolute expected pixel as well as the model.
  task automatic single_window(input string name, input int vals [N], input win_t w, input logic [15:0] want);
    logic [15:0] got;
    int seen;
    load_kernel(vals);
    got = '0; seen = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) cycle(1'b1, w, 1'b0, 0, 0);
      else cycle(1'b0, zw, 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL %s cycle %0d: got v=%b px=%h, expected v=%b px=%h", name, k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
      if (valid_out === 1'b1) begin seen++; got = pixel_out; end
    end
    if (seen != 1 || got !== want)
      $display("FAIL %s_value: got %h (%0d valid), expected %h", name, got, seen, want);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_box();
    int v [N];
    for (int t = 0; t < N; t++) v[t] = 4;
    single_window("box", v, fill_win(16'h8410), 16'h8410);
  endtask

  task automatic test_saturation();
    int v [N];
    win_t w;
    for (int t = 0; t < N; t++) v[t] = 8;
    single_window("sat_high", v, fill_win(16'hFFFF), 16'hFFFF);
    for (int t = 0; t < N; t++) v[t] = (t == 10) ? -64 : 0;
    w = '0; w[2][2] = 16'hFFFF;
    single_window("sat_low", v, w, 16'h0000);
  endtask

  task automatic test_rounding();
    int v [N];
    win_t w;
    for (int t = 0; t < N; t++) v[t] = (t == 10) ? 32 : 0;
    w = '0; w[2][2] = 16'h1863;
    single_window("round", v, w, 16'h1042);
  endtask

  // Tap 10 rewritten to the largest positive coefficient alongside window 5; window 5 keeps the old kernel.
  task automatic test_coef_midstream();
    int v [N];
    logic [15:0] got [$];
    int run, maxrun;
    for (int t = 0; t < N; t++) v[t] = (t == 10) ? 64 : 0;
    load_kernel(v);
    run = 0; maxrun = 0;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 10) cycle(1'b1, fill_win(16'h0821), (k == 5), 10, 127);
      else cycle(1'b0, zw, 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL midstream cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
      if (valid_out === 1'b1) begin got.push_back(pixel_out); run++; end
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    if (got.size() != 10 || maxrun != 10)
      $display("FAIL midstream_count: got %0d outputs (run %0d), expected 10 continuous", got.size(), maxrun);
    else n_pass++;
    n_total++;
    for (int k = 0; k < got.size(); k++) begin
      if (got[k] !== ((k < 5) ? 16'h0821 : 16'h1042))
        $display("FAIL midstream_out%0d: got %h, expected %h", k + 1, got[k], (k < 5) ? 16'h0821 : 16'h1042);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_back_to_back();
    int v [N];
    for (int t = 0; t < N; t++) v[t] = int'($urandom_range(0, 30)) - 8;
    load_kernel(v);
    for (int k = 1; k <= 32; k++) begin
      if (k <= 24) cycle(1'b1, rand_win(), 1'b0, 0, 0);
      else cycle(1'b0, zw, 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL back_to_back cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_random();
    logic v, w_en;
    int a, d;
    for (int k = 1; k <= 300; k++) begin
      v    = ($urandom_range(0, 3) != 0) && (k <= 290);
      w_en = ($urandom_range(0, 4) == 0) && (k <= 290);
      a    = int'($urandom_range(0, 15));
      d    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) - 12 : int'($urandom_range(0, 255)) - 128;
      cycle(v, rand_win(), w_en, a, d);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL random cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
    end
    if (exp_q.size() != 0) $display("FAIL random_drain: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_midstream();
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, rand_win(), 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL rst_mid_pre cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
    end
    #2 rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    if (valid_out !== 1'b0) $display("FAIL rst_mid_async: got valid_out=%b, expected 0", valid_out);
    else n_pass++;
    n_total++;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, zw, 1'b0, 0, 0);
      if ({valid_out, pixel_out} !== {exp_v, exp_px})
        $display("FAIL rst_mid_post cycle %0d: got v=%b px=%h, expected v=%b px=%h", k, valid_out, pixel_out, exp_v, exp_px);
      else n_pass++;
      n_total++;
    end
    test_identity();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_identity();
    test_box();
    test_saturation();
    test_rounding();
    test_coef_midstream();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
